// File: rtl/seg7_mux_counter.sv
// Hex/BCD up-down counter with a time-multiplexed common-segment 7-seg driver.
// Counts on a prescaled tick and refreshes one digit per slot, with zero blanking.
module seg7_mux_counter #(
    parameter int DIGITS      = 2,
    parameter int TICK_DIV    = 4194304,
    parameter int REFRESH_DIV = 6000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  mode_dec,
    input  logic                  blank_lz,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     dig_en
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    logic [PW-1:0] pre;
    logic [RW-1:0] rfr;
    logic [IW-1:0] idx;
    logic          tick;

    logic [W-1:0]  hex_next;
    logic          hex_wrap;
    logic [W-1:0]  bcd_next;
    logic          bcd_wrap;
    logic [W-1:0]  load_next;

    logic [3:0]        nib;
    logic              blank;
    logic [DIGITS-1:0] onehot;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    assign tick = en && (pre == PMAX);

    always_comb begin
        hex_next = dir ? (count + W'(1)) : (count - W'(1));
        hex_wrap = dir ? (&count) : ~(|count);
    end

    // Ripple carry/borrow through the decimal digits; bad nibbles act as 9.
    always_comb begin
        logic [3:0] d;
        logic       c;
        bcd_next  = '0;
        load_next = load_val;
        c         = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (d > 4'd9) d = 4'd9;
            if (c) begin
                if (dir) begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            bcd_next[4*i +: 4] = d;
            if (mode_dec && load_val[4*i +: 4] > 4'd9)
                load_next[4*i +: 4] = 4'd9;
        end
        bcd_wrap = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            pre   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_next;
                pre   <= '0;
            end else begin
                if (en)
                    pre <= tick ? '0 : pre + PW'(1);
                if (tick) begin
                    count <= mode_dec ? bcd_next : hex_next;
                    wrap  <= mode_dec ? bcd_wrap : hex_wrap;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfr <= '0;
            idx <= '0;
        end else if (rfr == RMAX) begin
            rfr <= '0;
            idx <= (idx == IMAX) ? '0 : idx + IW'(1);
        end else begin
            rfr <= rfr + RW'(1);
        end
    end

    // A digit is blank only when it and every digit above it are zero.
    always_comb begin
        nib   = 4'(count >> {idx, 2'b00});
        blank = blank_lz && (idx != '0) && ((count >> {idx, 2'b00}) == '0);
        for (int i = 0; i < DIGITS; i++)
            onehot[i] = (idx == IW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n  <= 7'h7F;
            dig_en <= '0;
        end else begin
            seg_n  <= blank ? 7'h7F : glyph(nib);
            dig_en <= onehot;
        end
    end

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Bench for seg7_mux_counter: decimal/modular reference model checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_seg7_mux_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       mode_dec = 1'b0;
    logic       blank_lz = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] count;
    logic       wrap;
    logic [6:0] seg_n;
    logic [1:0] dig_en;

    int checks = 0;
    int errors = 0;

    seg7_mux_counter #(
        .DIGITS(2),
        .TICK_DIV(4),
        .REFRESH_DIV(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .dir(dir),
        .mode_dec(mode_dec),
        .blank_lz(blank_lz),
        .load(load),
        .load_val(load_val),
        .count(count),
        .wrap(wrap),
        .seg_n(seg_n),
        .dig_en(dig_en)
    );

    always #5 clk = ~clk;

    logic [6:0] gly [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Decimal view of a two-digit BCD word, digits above 9 read as 9.
    function automatic int to_dec(input int v);
        int hi = (v >> 4) & 15;
        int lo = v & 15;
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic int to_bcd(input int d);
        return ((d / 10) << 4) | (d % 10);
    endfunction

    int         m_count = 0;
    int         m_pre = 0;
    int         m_ref = 0;
    int         m_idx = 0;
    int         m_v;
    int         m_nib;
    bit         m_wrap = 0;
    bit         m_tick;
    logic [6:0] m_seg = 7'h7F;
    logic [1:0] m_dig = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_pre = 0; m_ref = 0; m_idx = 0;
            m_wrap = 0; m_seg = 7'h7F; m_dig = 2'b00;
        end else begin
            m_dig = (m_idx == 0) ? 2'b01 : 2'b10;
            m_nib = (m_idx == 0) ? (m_count & 15) : ((m_count >> 4) & 15);
            if (blank_lz && m_idx == 1 && (m_count >> 4) == 0)
                m_seg = 7'h7F;
            else
                m_seg = gly[m_nib];
            if (m_ref == 2) begin
                m_ref = 0;
                m_idx = (m_idx + 1) % 2;
            end else begin
                m_ref++;
            end
            m_tick = en && (m_pre == 3);
            m_wrap = 0;
            if (load) begin
                m_count = mode_dec ? to_bcd(to_dec(int'(load_val)))
                                   : int'(load_val);
                m_pre = 0;
            end else begin
                if (m_tick) begin
                    if (mode_dec) begin
                        m_v = to_dec(m_count);
                        if (dir) begin
                            m_wrap = (m_v == 99);
                            m_v = (m_v + 1) % 100;
                        end else begin
                            m_wrap = (m_v == 0);
                            m_v = (m_v + 99) % 100;
                        end
                        m_count = to_bcd(m_v);
                    end else begin
                        m_wrap = dir ? (m_count == 255) : (m_count == 0);
                        m_count = (m_count + (dir ? 1 : 255)) % 256;
                    end
                end
                if (en) m_pre = (m_pre + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        chk("count", 32'(count), 32'(m_count));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("seg_n", 32'(seg_n), 32'(m_seg));
        chk("dig_en", 32'(dig_en), 32'(m_dig));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dig", 32'(dig_en), 32'h0);
        rst_n = 1'b1; en = 1'b1; dir = 1'b1;

        cyc(3);
        chk("s1_hold", 32'(count), 32'h00);
        cyc(1);
        chk("s1_step1", 32'(count), 32'h01);
        cyc(4);
        chk("s1_step2", 32'(count), 32'h02);
        do_load(8'hFE);
        chk("s1_load", 32'(count), 32'hFE);
        cyc(4);
        chk("s1_ff", 32'(count), 32'hFF);
        cyc(4);
        chk("s1_00", 32'(count), 32'h00);
        chk("s1_wrap", 32'(wrap), 32'h1);
        cyc(1);
        chk("s1_wrap_end", 32'(wrap), 32'h0);

        mode_dec = 1'b1;
        do_load(8'h98);
        cyc(4);
        chk("s2_99", 32'(count), 32'h99);
        cyc(4);
        chk("s2_00", 32'(count), 32'h00);
        chk("s2_wrap", 32'(wrap), 32'h1);
        do_load(8'h3C);
        chk("s2_clamp", 32'(count), 32'h39);

        dir = 1'b0;
        do_load(8'h10);
        cyc(4);
        chk("s3_09", 32'(count), 32'h09);
        cyc(4);
        chk("s3_08", 32'(count), 32'h08);
        do_load(8'h00);
        cyc(4);
        chk("s3_99", 32'(count), 32'h99);
        chk("s3_wrap", 32'(wrap), 32'h1);

        mode_dec = 1'b0; dir = 1'b1;
        do_load(8'h20);
        cyc(3);
        do_load(8'h55);
        chk("s4_load", 32'(count), 32'h55);
        chk("s4_nowrap", 32'(wrap), 32'h0);
        cyc(3);
        chk("s4_hold", 32'(count), 32'h55);
        cyc(1);
        chk("s4_step", 32'(count), 32'h56);

        en = 1'b0; blank_lz = 1'b1;
        do_load(8'h07);
        cyc(1);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (dig_en == 2'b01) begin
                chk("s5_seg_lo", 32'(seg_n), 32'h0F);
            end else begin
                chk("s5_dig_hi", 32'(dig_en), 32'h2);
                chk("s5_blank", 32'(seg_n), 32'h7F);
            end
        end
        blank_lz = 1'b0;
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (dig_en == 2'b10)
                chk("s5_zero", 32'(seg_n), 32'h01);
        end

        en = 1'b1;
        cyc(6);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_count", 32'(count), 32'h0);
        chk("s6_dig", 32'(dig_en), 32'h0);
        chk("s6_seg", 32'(seg_n), 32'h7F);
        chk("s6_wrap", 32'(wrap), 32'h0);
        cyc(1);
        rst_n = 1'b1; en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("s6_idle", 32'(count), 32'h0);
            chk("s6_nowrap", 32'(wrap), 32'h0);
        end

        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) dir = $urandom_range(0, 1);
            if ($urandom_range(0, 31) == 0) mode_dec = $urandom_range(0, 1);
            if ($urandom_range(0, 31) == 0) blank_lz = $urandom_range(0, 1);
            load = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 5))
                0: load_val = 8'h00;
                1: load_val = 8'hFF;
                2: load_val = 8'h99;
                3: load_val = 8'h01;
                default: load_val = 8'($urandom);
            endcase
            if (i == 700) begin
                #3 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            cyc(1);
        end
        load = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
